// File: rtl/count_ones_sm.sv
// Serial ones-counter: captures a word on start and counts its set bits one per clock.
// Moore FSM with registered busy/done; restarts directly from WAITING on a new start.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | after reset, waiting for the first start
// S_COUNTING | shifting the captured word right, accumulating bit 0
// S_WAITING  | shift register empty, bit_count valid until next start
module count_ones_sm #(
    parameter int counter_size = 3,
    parameter int word_size    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [word_size-1:0]    data,
    input  logic                    start,
    output logic [counter_size-1:0] bit_count,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_COUNTING = 2'b01,
        S_WAITING  = 2'b10
    } state_t;

    state_t                  r_state;
    logic [word_size-1:0]    r_temp;
    logic [counter_size-1:0] r_bit_count;
    logic                    r_busy;
    logic                    r_done;

    // busy/done are registered alongside the state so they mirror the state exactly
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_temp      <= '0;
            r_bit_count <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_WAITING: begin
                    if (start) begin
                        r_temp      <= data;
                        r_bit_count <= '0;
                        r_state     <= S_COUNTING;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                    end
                end
                S_COUNTING: begin
                    if (r_temp != '0) begin
                        r_bit_count <= r_bit_count + counter_size'(r_temp[0]);
                        r_temp      <= r_temp >> 1;
                    end else begin
                        r_state <= S_WAITING;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bit_count = r_bit_count;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_count_ones_sm.sv
// Self-checking bench for count_ones_sm: directed words plus random words
// compared against a popcount / highest-set-bit reference model.
module tb_count_ones_sm;

    logic       clk;
    logic       reset;
    logic [3:0] data;
    logic       start;
    logic [2:0] bit_count;
    logic       busy;
    logic       done;

    int asserts  = 0;
    int failures = 0;

    count_ones_sm #(.counter_size(3), .word_size(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .data      (data),
        .start     (start),
        .bit_count (bit_count),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: result is the number of ones; busy lasts (highest set bit index + 1) + 1 cycles
    function automatic int ref_count(input logic [3:0] d);
        int c = 0;
        for (int i = 0; i < 4; i++) if (d[i]) c++;
        return c;
    endfunction

    function automatic int ref_busy(input logic [3:0] d);
        int h = 0;
        for (int i = 0; i < 4; i++) if (d[i]) h = i + 1;
        return h + 1;
    endfunction

    // Issues one start pulse and measures; called just after a rising edge
    task automatic do_count(input logic [3:0] d, output int n_busy, output logic [2:0] cnt0,
                            output logic done_o, output logic [2:0] cnt_o, output logic tmo);
        start = 1'b1;
        data  = d;
        @(posedge clk); #1;
        start = 1'b0;
        data  = 4'($urandom);
        cnt0  = bit_count;
        n_busy = 0;
        while (busy === 1'b1 && n_busy < 20) begin
            n_busy++;
            @(posedge clk); #1;
        end
        tmo    = (n_busy >= 20);
        done_o = done;
        cnt_o  = bit_count;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        data  = 4'h0;
        #12;
        asserts++;
        if ({busy, done, bit_count} !== 5'b0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b done=%b count=%0d, want 0 0 0", busy, done, bit_count);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        asserts++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL idle_hold: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [3:0] words [5] = '{4'hF, 4'h3, 4'h5, 4'hB, 4'h0};
        int n; logic [2:0] c0; logic dn; logic [2:0] c; logic tmo;
        for (int k = 0; k < 5; k++) begin
            do_count(words[k], n, c0, dn, c, tmo);
            asserts++;
            if (tmo || n != ref_busy(words[k])) begin
                failures++;
                $display("FAIL dir_busy_len data=%h: got %0d cycles, want %0d", words[k], n, ref_busy(words[k]));
            end
            asserts++;
            if (c0 !== 3'd0) begin
                failures++;
                $display("FAIL dir_count_clear data=%h: got %0d, want 0", words[k], c0);
            end
            asserts++;
            if (dn !== 1'b1 || c !== 3'(ref_count(words[k]))) begin
                failures++;
                $display("FAIL dir_result data=%h: got done=%b count=%0d, want 1 %0d", words[k], dn, c, ref_count(words[k]));
            end
        end
        @(posedge clk); #1;
        asserts++;
        if (done !== 1'b1 || busy !== 1'b0 || bit_count !== 3'd0) begin
            failures++;
            $display("FAIL wait_hold: got done=%b busy=%b count=%0d, want 1 0 0", done, busy, bit_count);
        end
    endtask

    task automatic test_random();
        int n; logic [2:0] c0; logic dn; logic [2:0] c; logic tmo;
        logic [3:0] d;
        for (int k = 0; k < 24; k++) begin
            d = 4'($urandom);
            do_count(d, n, c0, dn, c, tmo);
            asserts++;
            if (tmo || n != ref_busy(d) || dn !== 1'b1 || c !== 3'(ref_count(d))) begin
                failures++;
                $display("FAIL rand data=%h: got busy=%0d done=%b count=%0d, want %0d 1 %0d",
                         d, n, dn, c, ref_busy(d), ref_count(d));
            end
        end
    endtask

    task automatic test_ignore_inputs();
        int n = 0;
        start = 1'b1;
        data  = 4'hA;
        @(posedge clk); #1;
        while (busy === 1'b1 && n < 20) begin
            n++;
            start = 1'($urandom_range(0, 1));
            data  = 4'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;
        asserts++;
        if (n != ref_busy(4'hA) || done !== 1'b1 || bit_count !== 3'(ref_count(4'hA))) begin
            failures++;
            $display("FAIL ignore_inputs: got busy=%0d done=%b count=%0d, want %0d 1 %0d",
                     n, done, bit_count, ref_busy(4'hA), ref_count(4'hA));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [3:0] words [2] = '{4'h9, 4'hC};
        int n;
        start = 1'b1;
        data  = words[0];
        @(posedge clk); #1;
        data  = words[1];
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (busy === 1'b1 && n < 20) begin
                n++;
                @(posedge clk); #1;
            end
            if (k == 1) start = 1'b0;
            asserts++;
            if (n != ref_busy(words[k]) || done !== 1'b1 || bit_count !== 3'(ref_count(words[k]))) begin
                failures++;
                $display("FAIL held_start word%0d=%h: got busy=%0d done=%b count=%0d, want %0d 1 %0d",
                         k, words[k], n, done, bit_count, ref_busy(words[k]), ref_count(words[k]));
            end
            @(posedge clk); #1;
            asserts++;
            if (k == 0 && (done !== 1'b0 || busy !== 1'b1)) begin
                failures++;
                $display("FAIL held_pulse: got done=%b busy=%b, want 0 1", done, busy);
            end else if (k == 1 && (done !== 1'b1 || busy !== 1'b0)) begin
                failures++;
                $display("FAIL held_release: got done=%b busy=%b, want 1 0", done, busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n; logic [2:0] c0; logic dn; logic [2:0] c; logic tmo;
        start = 1'b1;
        data  = 4'hF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        asserts++;
        if ({busy, done, bit_count} !== 5'b0) begin
            failures++;
            $display("FAIL reset_mid: got busy=%b done=%b count=%0d, want 0 0 0", busy, done, bit_count);
        end
        #3;
        reset = 1'b1;
        @(posedge clk); #1;
        do_count(4'h7, n, c0, dn, c, tmo);
        asserts++;
        if (tmo || n != ref_busy(4'h7) || dn !== 1'b1 || c !== 3'(ref_count(4'h7))) begin
            failures++;
            $display("FAIL after_reset: got busy=%0d done=%b count=%0d, want %0d 1 %0d",
                     n, dn, c, ref_busy(4'h7), ref_count(4'h7));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_inputs();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
